// File: rtl/spell_mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the spell DFF memory select/data_ready port.
// One transaction per 7 cycles; optional BUSY timeout via SPELL_MEM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module spell_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       r0_valid,
    input  logic       r0_write,
    input  logic [1:0] r0_type,
    input  logic [7:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_done,
    output logic [7:0] r0_rdata,
    output logic       r0_error,
    input  logic       r1_valid,
    input  logic       r1_write,
    input  logic [1:0] r1_type,
    input  logic [7:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_done,
    output logic [7:0] r1_rdata,
    output logic       r1_error,
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    output logic [1:0] mem_memory_type,
    output logic       mem_write,
    input  logic [7:0] mem_data_out,
    input  logic       mem_data_ready,
    output logic       busy,
    output logic       grant
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   take, win, finish, tout;
    logic [7:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        win       = 1'b0;
        finish    = 1'b0;
        tout      = 1'b0;
        case (state)
            S_IDLE: begin
                if (r0_valid || r1_valid) begin
                    take      = 1'b1;
                    // contention goes to the port that did not win last time
                    win       = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_data_ready) begin
                    finish    = 1'b1;
                    state_nxt = S_RELEASE;
                end
`ifdef SPELL_MEM_ARB_TIMEOUT_EN
                else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    tout      = 1'b1;
                    state_nxt = S_RELEASE;
                end
`endif
            end
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_select      <= 1'b0;
            mem_addr        <= 8'd0;
            mem_data_in     <= 8'd0;
            mem_memory_type <= 2'd0;
            mem_write       <= 1'b0;
            r0_done         <= 1'b0;
            r1_done         <= 1'b0;
            r0_rdata        <= 8'd0;
            r1_rdata        <= 8'd0;
            busy            <= 1'b0;
            grant           <= 1'b0;
            last_grant      <= 1'b1;
        end else begin
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            if (take) begin
                mem_select      <= 1'b1;
                busy            <= 1'b1;
                grant           <= win;
                last_grant      <= win;
                mem_addr        <= win ? r1_addr  : r0_addr;
                mem_data_in     <= win ? r1_wdata : r0_wdata;
                mem_memory_type <= win ? r1_type  : r0_type;
                mem_write       <= win ? r1_write : r0_write;
            end
            if (finish || tout) begin
                mem_select <= 1'b0;
                if (grant) begin
                    r1_done  <= 1'b1;
                    r1_rdata <= (finish && !mem_write) ? mem_data_out : 8'd0;
                end else begin
                    r0_done  <= 1'b1;
                    r0_rdata <= (finish && !mem_write) ? mem_data_out : 8'd0;
                end
            end
            if (state == S_RELEASE) busy <= 1'b0;
        end
    end

`ifdef SPELL_MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= 8'd0;
            r0_error <= 1'b0;
            r1_error <= 1'b0;
        end else begin
            if (take)                 cnt <= 8'd0;
            else if (state == S_BUSY) cnt <= cnt + 8'd1;
            if (finish || tout) begin
                if (grant) r1_error <= tout;
                else       r0_error <= tout;
            end
        end
    end
`else
    assign cnt      = 8'd0;
    assign r0_error = 1'b0;
    assign r1_error = 1'b0;
`endif

endmodule

// File: doc/spell_mem_arbiter.md
# spell_mem_arbiter

Two-port arbiter and sequencer in front of the spell DFF memory (`spell_mem_dff`). It shares the single select/data_ready memory port between the core requester (port 0) and the loader/debug requester (port 1). Arbitration is round-robin. The block drives the memory's select-hold-release protocol, including the mandatory deselect cycle between transactions, and returns each result to the winning requester as a one-cycle done pulse.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum number of BUSY cycles before a transaction is aborted (used only with SPELL_MEM_ARB_TIMEOUT_EN); range 1..255.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  reset, synchronous, active-high
- rN_valid  in  1  request from port N (N = 0, 1); held until rN_done
- rN_write  in  1  1 = write, 0 = read
- rN_type  in  2  memory type (code/data), passed unchanged to the memory
- rN_addr  in  8  byte address
- rN_wdata  in  8  write data
- rN_done  out  1  one-cycle completion pulse
- rN_rdata  out  8  read data, valid while rN_done = 1; 0 for writes
- rN_error  out  1  set with rN_done when the transaction timed out
- mem_select  out  1  memory select
- mem_addr, mem_data_in  out  8  to the memory
- mem_memory_type  out  2  to the memory
- mem_write  out  1  to the memory
- mem_data_out  in  8  from the memory
- mem_data_ready  in  1  from the memory
- busy  out  1  high in BUSY and RELEASE
- grant  out  1  index of the current or most recent winner

## Operation
- State machine:
  - IDLE: mem_select = 0. If any rN_valid is high, pick a winner, register the winner's fields onto the mem_* outputs, and go to BUSY.
  - BUSY: mem_select = 1. On mem_data_ready = 1, capture mem_data_out (read) or 0 (write) into the winner's rN_rdata, pulse its rN_done, and go to RELEASE.
  - RELEASE: mem_select = 0 for exactly one cycle, then IDLE. This cycle re-arms the memory's latency counter.
- Round-robin:
  - last_grant resets to 1, so port 0 wins the first contention.
  - When both ports are valid, the port != last_grant wins.
  - When one port is valid, it wins.
  - last_grant updates on every grant.
- mem_addr, mem_data_in, mem_memory_type and mem_write are latched at grant and held stable through BUSY. Changes on rN_* during BUSY are ignored.
- If a requester drops rN_valid mid-transaction, the transaction still completes and rN_done still pulses.
- The losing port's rN_done stays 0. Its request is served next, after RELEASE and IDLE.
- All outputs are registered. Reset values:
  - state = IDLE
  - mem_select = 0, mem_write = 0, mem_addr = 0, mem_data_in = 0, mem_memory_type = 0
  - rN_done = 0, rN_rdata = 0, rN_error = 0
  - busy = 0, grant = 0
- Reset mid-transaction returns to IDLE immediately with mem_select = 0. No done pulse is issued for the aborted transaction.

## Timing
- Memory contract: after select has been low for at least one cycle, the memory asserts mem_data_ready on the 4th edge at which it samples mem_select = 1. mem_data_ready stays high until select drops.
- IDLE lasts at least one cycle after reset with mem_select = 0, which guarantees the memory is armed.
- Let cycle 0 be the cycle in which rN_valid is first seen in IDLE:
  - mem_select is high in cycles 1..5.
  - mem_data_ready is high in cycle 5.
  - rN_done = 1 and mem_select = 0 in cycle 6 (RELEASE).
  - IDLE is in cycle 7; the next mem_select rises in cycle 8.
- Sustained throughput: one transaction per 7 cycles.
- rN_done is never high for more than one consecutive cycle. r0_done and r1_done are never high simultaneously.

## Configuration
- SPELL_MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches TIMEOUT_CYCLES without mem_data_ready, the block goes to RELEASE, pulses rN_done with rN_error = 1 and rN_rdata = 0, and does not retry.
  - If mem_data_ready arrives in the same cycle as the timeout, the transaction completes normally with error = 0.
- SPELL_MEM_ARB_TIMEOUT_EN undefined:
  - There is no counter; BUSY waits indefinitely.
  - rN_error is tied to 0.

## Test plan
- Read after reset: preload data addr 0x10 = 0xA5; r0 read type=data addr 0x10 -> r0_done in cycle 6, r0_rdata = 0xA5, r0_error = 0.
- Write then read: r1 write code addr 0xFF data 0x3C, then r1 read code 0xFF -> write done with rdata = 0; read returns 0x3C; mem_select low exactly 1 cycle between the two transactions.
- Contention: r0 and r1 valid in the same cycle from reset, both held -> r0 served first, r1 done 7 cycles later, grant goes 0 then 1; with both re-requesting, the grants keep alternating.
- Mid-operation: r0 drops valid in cycle 2 -> r0_done still in cycle 6. Reset asserted in cycle 3 -> mem_select = 0 and busy = 0 in cycle 4, no done pulse.
- Timeout (SPELL_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): memory model never readies -> r0_done with r0_error = 1 and r0_rdata = 0 after 16 BUSY cycles; the next request completes normally.
- Without the macro: a stalled memory leaves busy = 1 indefinitely and r0_error never asserts.
